// File: rtl/mips_pkg.sv
// Shared types for the MIPS fetch-stage PC sequencer.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package mips_pkg;

    // Sequencer states: BOOT is a single-cycle launch, FETCH owns the imem
    // request, HOLD parks the fetched instruction while decode stalls.
    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } seq_state_t;

    // Redirect causes, encoded so that a numerically larger value wins.
    typedef enum logic [1:0] {
        RD_NONE   = 2'd0,
        RD_JUMP   = 2'd1,
        RD_BRANCH = 2'd2,
        RD_EXC    = 2'd3
    } redirect_cause_t;

    localparam logic [31:0] PC_STEP = 32'd4;

    // True when cause a strictly outranks cause b.
    function automatic logic cause_outranks(input redirect_cause_t a,
                                            input redirect_cause_t b);
        return (a > b);
    endfunction

endpackage

// File: rtl/pc_redirect_sel.sv
// Priority select of redirect cause/target (exc > branch > jump) and rank check vs the pending cause.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module pc_redirect_sel
    import mips_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0180
) (
    input  logic            exc,
    input  logic            branch_taken,
    input  logic [31:0]     branch_target,
    input  logic            jump,
    input  logic [31:0]     jump_target,
    input  redirect_cause_t pend_cause,
    output redirect_cause_t cause,
    output logic [31:0]     target,
    output logic            outranks_pend
);

    // Highest-priority active request decides cause and target.
    always_comb begin
        cause  = RD_NONE;
        target = 32'h0;
        if (exc) begin
            cause  = RD_EXC;
            target = EXC_VECTOR;
        end else if (branch_taken) begin
            cause  = RD_BRANCH;
            target = branch_target;
        end else if (jump) begin
            cause  = RD_JUMP;
            target = jump_target;
        end
        outranks_pend = cause_outranks(cause, pend_cause);
    end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller: sequences imem fetches and picks next PC (exc > branch > jump > +4); records EPC.
// Latency: pc_next combinational; instr/instr_valid one cycle after imem_ack; one instr per cycle on back-to-back acks.
// Backpressure: holds PC while imem_ack is low or stall is high; optional watchdog via PC_SEQ_TIMEOUT_EN.
module pc_sequencer
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR     = 32'h0000_0180,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_cur,
    output logic [31:0] pc_next,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        exc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] epc,
    output logic        fetch_err
);

    // A zero-cycle watchdog would fire before any memory could answer.
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("pc_sequencer: TIMEOUT_CYCLES must be at least 1");
    end

    seq_state_t      state, state_nxt;
    redirect_cause_t pend_cause, pend_cause_nxt;
    logic [31:0]     pend_target, pend_target_nxt;
    logic            instr_valid_nxt;
    logic [31:0]     instr_nxt;
    logic [31:0]     epc_nxt;
    logic            timeout_hit;

    redirect_cause_t new_cause;
    logic [31:0]     new_target;
    logic            new_wins;
    redirect_cause_t eff_cause;
    logic [31:0]     eff_target;

    pc_redirect_sel #(
        .EXC_VECTOR (EXC_VECTOR)
    ) u_sel (
        .exc           (exc),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .pend_cause    (pend_cause),
        .cause         (new_cause),
        .target        (new_target),
        .outranks_pend (new_wins)
    );

    // The pending redirect stands unless a strictly higher-priority one arrives.
    always_comb begin
        eff_cause  = pend_cause;
        eff_target = pend_target;
        if (new_wins) begin
            eff_cause  = new_cause;
            eff_target = new_target;
        end
    end

`ifdef PC_SEQ_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CNT_W-1:0] to_cnt;

    assign timeout_hit = (state == ST_FETCH) && !imem_ack
                         && (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Watchdog counts consecutive unanswered FETCH cycles; one-cycle error pulse on expiry.
    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt    <= '0;
            fetch_err <= 1'b0;
        end else begin
            fetch_err <= timeout_hit;
            if ((state == ST_FETCH) && !imem_ack && !timeout_hit) begin
                to_cnt <= to_cnt + 1'b1;
            end else begin
                to_cnt <= '0;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign fetch_err   = 1'b0;
`endif

    // Next-state, next-PC and register-update decisions.
    always_comb begin
        state_nxt       = state;
        pc_next         = pc_cur;
        imem_req        = 1'b0;
        imem_addr       = pc_cur;
        pend_cause_nxt  = pend_cause;
        pend_target_nxt = pend_target;
        instr_valid_nxt = instr_valid;
        instr_nxt       = instr;
        epc_nxt         = epc;

        unique case (state)
            ST_BOOT: begin
                pc_next         = RESET_VECTOR;
                instr_valid_nxt = 1'b0;
                pend_cause_nxt  = RD_NONE;
                state_nxt       = ST_FETCH;
            end

            ST_FETCH: begin
                imem_req        = 1'b1;
                instr_valid_nxt = 1'b0;
                if (timeout_hit) begin
                    pc_next        = EXC_VECTOR;
                    epc_nxt        = pc_cur;
                    pend_cause_nxt = RD_NONE;
                end else if (!imem_ack) begin
                    // Keep requesting the same address; remember the best redirect seen.
                    if (new_wins) begin
                        pend_cause_nxt  = new_cause;
                        pend_target_nxt = new_target;
                        if (new_cause == RD_EXC) begin
                            epc_nxt = pc_cur;
                        end
                    end
                end else if (eff_cause != RD_NONE) begin
                    // Fetched word belongs to the wrong path: drop it.
                    pc_next        = eff_target;
                    pend_cause_nxt = RD_NONE;
                    if (new_wins && (new_cause == RD_EXC)) begin
                        epc_nxt = pc_cur;
                    end
                end else begin
                    instr_nxt       = imem_rdata;
                    instr_valid_nxt = 1'b1;
                    if (stall) begin
                        state_nxt = ST_HOLD;
                    end else begin
                        pc_next = pc_cur + PC_STEP;
                    end
                end
            end

            ST_HOLD: begin
                if (new_cause != RD_NONE) begin
                    pc_next         = new_target;
                    instr_valid_nxt = 1'b0;
                    state_nxt       = ST_FETCH;
                    if (new_cause == RD_EXC) begin
                        epc_nxt = pc_cur;
                    end
                end else if (!stall) begin
                    pc_next         = pc_cur + PC_STEP;
                    instr_valid_nxt = 1'b0;
                    state_nxt       = ST_FETCH;
                end
            end

            default: begin
                state_nxt = ST_BOOT;
            end
        endcase

        // Reset dominates the combinational outputs regardless of state.
        if (reset) begin
            pc_next  = RESET_VECTOR;
            imem_req = 1'b0;
        end
    end

    // State, pending redirect, fetched instruction and EPC registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_BOOT;
            pend_cause  <= RD_NONE;
            pend_target <= 32'h0;
            instr_valid <= 1'b0;
            instr       <= 32'h0;
            epc         <= 32'h0;
        end else begin
            state       <= state_nxt;
            pend_cause  <= pend_cause_nxt;
            pend_target <= pend_target_nxt;
            instr_valid <= instr_valid_nxt;
            instr       <= instr_nxt;
            epc         <= epc_nxt;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: models the external pc register and a simple imem.
// Latency: n/a.
// Backpressure: bench drives imem_ack/stall directly.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_cur = 32'h0;
    logic [31:0] pc_next;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        exc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] epc;
    logic        fetch_err;

    int n_checks = 0;
    int n_errors = 0;

`ifdef PC_SEQ_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    pc_sequencer #(
        .RESET_VECTOR   (32'h0000_0000),
        .EXC_VECTOR     (32'h0000_0180),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pc_cur        (pc_cur),
        .pc_next       (pc_next),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .exc           (exc),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .epc           (epc),
        .fetch_err     (fetch_err)
    );

    always #5 clk = ~clk;

    // External pc register.
    always_ff @(posedge clk) pc_cur <= pc_next;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic to_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        jump          = 1'b0;
        jump_target   = 32'h0;
        exc           = 1'b0;
        imem_ack      = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        reset = 1'b1;
        idle();
        // Reset held two cycles.
        to_pos();
        to_neg();
        chk("rst_pc_next", pc_next, 32'h0);
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        chk("rst_valid", {31'h0, instr_valid}, 32'h0);
        chk("rst_epc", epc, 32'h0);
        chk("rst_err", {31'h0, fetch_err}, 32'h0);
        to_pos();
        reset = 1'b0;
        to_neg();
        chk("boot_pc_next", pc_next, 32'h0);
        chk("boot_req", {31'h0, imem_req}, 32'h0);
        to_pos();

        // Sequential fetch, ack every cycle.
        for (int i = 0; i < 4; i++) begin
            imem_ack = 1'b1;
            to_neg();
            chk("seq_req", {31'h0, imem_req}, 32'h1);
            chk("seq_addr", imem_addr, 32'(4 * i));
            chk("seq_pc_next", pc_next, 32'(4 * i + 4));
            if (i > 0) begin
                chk("seq_instr", instr, mem_word(32'(4 * (i - 1))));
                chk("seq_valid", {31'h0, instr_valid}, 32'h1);
            end
            to_pos();
        end

        // Slow memory: three cycles without ack.
        idle();
        for (int w = 0; w < 3; w++) begin
            to_neg();
            chk("slow_pc_next", pc_next, 32'h10);
            chk("slow_addr", imem_addr, 32'h10);
            if (w == 0) begin
                chk("slow_last_instr", instr, mem_word(32'hC));
                chk("slow_last_valid", {31'h0, instr_valid}, 32'h1);
            end else begin
                chk("slow_valid", {31'h0, instr_valid}, 32'h0);
            end
            to_pos();
        end
        imem_ack = 1'b1;
        stall    = 1'b1;
        to_neg();
        chk("stall_ack_pc_next", pc_next, 32'h10);
        to_pos();
        imem_ack = 1'b0;
        for (int h = 0; h < 2; h++) begin
            to_neg();
            chk("hold_req", {31'h0, imem_req}, 32'h0);
            chk("hold_pc_next", pc_next, 32'h10);
            chk("hold_instr", instr, mem_word(32'h10));
            chk("hold_valid", {31'h0, instr_valid}, 32'h1);
            to_pos();
        end
        stall = 1'b0;
        to_neg();
        chk("resume_pc_next", pc_next, 32'h14);
        to_pos();
        to_neg();
        chk("resume_valid", {31'h0, instr_valid}, 32'h0);
        chk("resume_addr", imem_addr, 32'h14);
        to_pos();

        // Branch while waiting: data dropped, redirect on ack.
        branch_taken  = 1'b1;
        branch_target = 32'h40;
        to_neg();
        chk("br_wait_pc_next", pc_next, 32'h14);
        to_pos();
        idle();
        to_neg();
        chk("br_wait2_pc_next", pc_next, 32'h14);
        to_pos();
        imem_ack = 1'b1;
        to_neg();
        chk("br_ack_pc_next", pc_next, 32'h40);
        to_pos();
        idle();
        to_neg();
        chk("br_drop_valid", {31'h0, instr_valid}, 32'h0);
        chk("br_addr", imem_addr, 32'h40);
        to_pos();

        // Pending branch beats a later jump.
        branch_taken  = 1'b1;
        branch_target = 32'h60;
        to_pos();
        idle();
        jump        = 1'b1;
        jump_target = 32'h80;
        to_neg();
        chk("jmp_ignored_wait", pc_next, 32'h40);
        to_pos();
        idle();
        imem_ack = 1'b1;
        to_neg();
        chk("pend_br_wins", pc_next, 32'h60);
        to_pos();

        // Move to 0x1C, then exc + branch + ack together.
        jump        = 1'b1;
        jump_target = 32'h1C;
        to_neg();
        chk("jmp_ack_pc_next", pc_next, 32'h1C);
        to_pos();
        idle();
        exc           = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 32'h40;
        imem_ack      = 1'b1;
        to_neg();
        chk("exc_pc_next", pc_next, 32'h180);
        to_pos();
        idle();
        to_neg();
        chk("exc_epc", epc, 32'h1C);
        chk("exc_valid", {31'h0, instr_valid}, 32'h0);
        chk("exc_addr", imem_addr, 32'h180);
        to_pos();

        // Redirect while in HOLD overrides stall.
        imem_ack = 1'b1;
        stall    = 1'b1;
        to_pos();
        imem_ack    = 1'b0;
        jump        = 1'b1;
        jump_target = 32'h200;
        to_neg();
        chk("hold_jmp_pc_next", pc_next, 32'h200);
        to_pos();
        idle();
        to_neg();
        chk("hold_jmp_valid", {31'h0, instr_valid}, 32'h0);
        chk("hold_jmp_req", {31'h0, imem_req}, 32'h1);
        chk("hold_jmp_addr", imem_addr, 32'h200);
        to_pos();

        // Pending exc replaces a pending branch.
        branch_taken  = 1'b1;
        branch_target = 32'h300;
        to_pos();
        idle();
        exc = 1'b1;
        to_pos();
        idle();
        imem_ack = 1'b1;
        to_neg();
        chk("pend_exc_pc_next", pc_next, 32'h180);
        chk("pend_exc_epc", epc, 32'h200);
        to_pos();

        // PC wraps past 0xFFFF_FFFC.
        jump        = 1'b1;
        jump_target = 32'hFFFF_FFFC;
        to_pos();
        idle();
        imem_ack = 1'b1;
        to_neg();
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        chk("wrap_pc_next", pc_next, 32'h0);
        to_pos();

        // Watchdog at 0x20.
        jump        = 1'b1;
        jump_target = 32'h20;
        to_pos();
        idle();
        for (int w = 0; w < 4; w++) begin
            to_neg();
            if (TO_EN && (w == 3)) chk("to_pc_next_fire", pc_next, 32'h180);
            else                   chk("to_pc_next_wait", pc_next, 32'h20);
            chk("to_err_low", {31'h0, fetch_err}, 32'h0);
            to_pos();
        end
        to_neg();
        chk("to_err_pulse", {31'h0, fetch_err}, {31'h0, TO_EN});
        chk("to_epc", epc, TO_EN ? 32'h20 : 32'h200);
        to_pos();
        to_neg();
        chk("to_err_clear", {31'h0, fetch_err}, 32'h0);
        to_pos();

        // Reset mid-fetch; a late ack in BOOT is ignored.
        reset = 1'b1;
        to_neg();
        chk("mid_rst_pc_next", pc_next, 32'h0);
        chk("mid_rst_req", {31'h0, imem_req}, 32'h0);
        to_pos();
        reset    = 1'b0;
        imem_ack = 1'b1;
        to_neg();
        chk("late_ack_req", {31'h0, imem_req}, 32'h0);
        chk("late_ack_pc_next", pc_next, 32'h0);
        to_pos();
        idle();
        to_neg();
        chk("late_ack_valid", {31'h0, instr_valid}, 32'h0);
        chk("post_rst_epc", epc, 32'h0);
        chk("post_rst_addr", imem_addr, 32'h0);
        chk("post_rst_req", {31'h0, imem_req}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Next-PC controller for the MIPS fetch stage. It drives `pc_in` of the existing `pc` register and reads back its `pc_out`. It sequences instruction-memory fetches over a req/ack handshake and chooses the next PC by priority: exception, branch, jump, then sequential. It also holds the PC on pipeline stalls and slow memory, and records the EPC.

## Interface
Parameters:
- `RESET_VECTOR`, default 32'h0000_0000: first fetch address after reset.
- `EXC_VECTOR`, default 32'h0000_0180: exception handler address.
- `TIMEOUT_CYCLES`, default 16: fetch watchdog limit (used only with the macro defined).

Ports. One clock; reset is synchronous and active-high.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `pc_cur`  in  32  current PC, from `pc_out` of `pc`.
- `pc_next`  out  32  to `pc_in` of `pc`; combinational.
- `stall`  in  1  decode hazard; hold the fetched instruction.
- `branch_taken`  in  1  redirect request; `branch_target`  in  32.
- `jump`  in  1  redirect request; `jump_target`  in  32.
- `exc`  in  1  exception request.
- `imem_req`  out  1  fetch request; `imem_addr`  out  32.
- `imem_ack`  in  1  fetch complete; `imem_rdata`  in  32.
- `instr_valid`  out  1  registered; `instr`  out  32  registered.
- `epc`  out  32  registered PC at the time of the exception.
- `fetch_err`  out  1  registered watchdog flag (macro only).

## Operation
- States: BOOT, FETCH, HOLD.
- Reset:
  - State goes to BOOT.
  - `instr_valid`=0, `instr`=0, `epc`=0, `fetch_err`=0, pending redirect cleared.
  - While `reset` is high, `pc_next`=RESET_VECTOR and `imem_req`=0.
- BOOT, one cycle only: `pc_next`=RESET_VECTOR, `imem_req`=0, then go to FETCH.
- FETCH:
  - `imem_req`=1 and `imem_addr`=`pc_cur`. The address stays stable until ack.
  - No ack: `pc_next`=`pc_cur`.
  - Ack with no redirect: capture `imem_rdata` into `instr`; `instr_valid`=1 next cycle.
    - `stall`=0: `pc_next`=`pc_cur`+4 (mod 2^32; 0xFFFF_FFFC wraps to 0) and stay in FETCH.
    - `stall`=1: `pc_next`=`pc_cur` and go to HOLD.
- HOLD:
  - `imem_req`=0; `instr` and `instr_valid` are held.
  - On the cycle `stall` drops: `pc_next`=`pc_cur`+4 and go to FETCH. `instr_valid` goes low next cycle unless a new ack arrives.
- Redirect priority: `exc` > `branch_taken` > `jump`.
  - An `exc` redirect targets EXC_VECTOR and loads `epc`<=`pc_cur`.
- Redirect in FETCH without ack:
  - Latch the target in a pending register and keep requesting the same address.
  - A higher-priority request replaces the pending one; an equal or lower one is ignored.
  - When ack arrives, discard the data (`instr_valid`=0) and set `pc_next`=pending target.
- Redirect in the same cycle as ack, or while in HOLD:
  - `pc_next`=target and the fetched or held instruction is dropped.
  - `instr_valid`=0 next cycle; go to FETCH.
- `stall` is ignored while a redirect applies.

## Timing
- `pc_next` is combinational; `pc_cur` reflects it one edge later.
- Back-to-back acks give one instruction per cycle.
- Fetch latency: ack in cycle N gives `instr_valid` in cycle N+1.
- Reset mid-fetch abandons the outstanding request; a late ack after reset is ignored in BOOT.

## Configuration
- `PC_SEQ_TIMEOUT_EN` defined:
  - A counter runs while FETCH waits for ack.
  - After TIMEOUT_CYCLES cycles without ack: `fetch_err` pulses for 1 cycle, `pc_next`=EXC_VECTOR, `epc`<=`pc_cur`, pending redirect cleared, counter reset.
- `PC_SEQ_TIMEOUT_EN` not defined: no counter, `fetch_err` is tied to 0, and the sequencer waits indefinitely.

## Structure
- Shared package `mips_pkg`:
  - state enum (BOOT/FETCH/HOLD).
  - redirect-cause encoding (NONE/JUMP/BRANCH/EXC).
  - `PC_STEP`=4.
- Sub-module `pc_redirect_sel`: combinational priority select of cause and target, instantiated once for new requests and reused to compare against the pending cause.

## Test plan
- Reset:
  - Reset held 2 cycles, then released → `pc_next`=0 and `imem_req`=0 during BOOT.
  - Next cycle `imem_req`=1 and `imem_addr`=0.
- Sequential fetch, ack every cycle, stall=0:
  - `imem_addr` goes 0, 4, 8, 0xC.
  - `instr` follows `imem_rdata` one cycle later, with `instr_valid` continuously 1.
- Slow memory and stall:
  - Ack after 3 cycles → `pc_next`=`pc_cur` for 3 cycles.
  - Then stall for 2 cycles → state HOLD with `instr` held, then resume at +4.
- Branch while waiting:
  - `branch_taken` with target 0x40 at cycle 1, ack at cycle 3 → data dropped, `pc_next`=0x40.
  - Then a jump to 0x80 during the next wait → ignored in favour of the pending exc/branch per priority rules.
- Simultaneous events:
  - `exc`, `branch_taken` and ack in one cycle at `pc_cur`=0x1C → `pc_next`=0x180, `epc`=0x1C, `instr_valid`=0 next cycle.
- Timeout (macro defined, TIMEOUT_CYCLES=4):
  - No ack for 4 cycles at 0x20 → `fetch_err` pulse, `pc_next`=0x180, `epc`=0x20.
  - Macro undefined → `fetch_err` stays 0.
